// File: rtl/cache_pkg.sv
// Shared types for the coherent cache controller: line states, CPU ops,
// ACE request kinds, MSHR entry states and the fill-state mapping.
package cache_pkg;

    typedef enum logic [2:0] {
        LS_UC = 3'b001,
        LS_SC = 3'b010,
        LS_UD = 3'b011,
        LS_I  = 3'b100,
        LS_SD = 3'b101
    } line_state_e;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01
    } cpu_op_e;

    typedef enum logic [1:0] {
        ACE_READ_SHARED  = 2'b00,
        ACE_READ_UNIQUE  = 2'b01,
        ACE_CLEAN_UNIQUE = 2'b10
    } ace_req_e;

    typedef enum logic [1:0] {
        MSHR_FREE = 2'b00,
        MSHR_PEND = 2'b01,
        MSHR_WAIT = 2'b10
    } mshr_state_e;

    // Unknown encodings count as Invalid, so only the four legal valid codes hit.
    function automatic logic is_valid_line(input logic [2:0] st);
        return (st == LS_UC) || (st == LS_SC) || (st == LS_UD) || (st == LS_SD);
    endfunction

    function automatic line_state_e fill_state(input logic shared, input logic dirty);
        case ({shared, dirty})
            2'b00:   return LS_UC;
            2'b01:   return LS_UD;
            2'b10:   return LS_SC;
            default: return LS_SD;
        endcase
    endfunction

endpackage

// File: rtl/cache_mshr_entry.sv
// One outstanding-miss entry: lifecycle FSM, captured line address and
// request kind, and the address-conflict compare against the CPU lookup.
module cache_mshr_entry
    import cache_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alloc,
    input  logic [ADDR_W-1:0] alloc_addr,
    input  logic [1:0]        alloc_type,
    input  logic              issue,
    input  logic              retire,
    input  logic [ADDR_W-1:0] cmp_addr,
    output logic [1:0]        state,
    output logic [ADDR_W-1:0] addr,
    output logic [1:0]        req_type,
    output logic              match
);

    mshr_state_e       state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        type_q;

    // NOTE: state_d gets its current value first so every path assigns it and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            MSHR_FREE: if (alloc)  state_d = MSHR_PEND;
            MSHR_PEND: if (issue)  state_d = MSHR_WAIT;
            MSHR_WAIT: if (retire) state_d = MSHR_FREE;
            default:               state_d = MSHR_FREE;
        endcase
    end

    // NOTE: flops use non-blocking assignment so all registers see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= MSHR_FREE;
        else        state_q <= state_d;
    end

    // NOTE: payload is only read while the entry is non-FREE, so it carries no reset.
    always_ff @(posedge clk) begin
        if (alloc) begin
            addr_q <= alloc_addr;
            type_q <= alloc_type;
        end
    end

    assign state    = state_q;
    assign addr     = addr_q;
    assign req_type = type_q;
    assign match    = (state_q != MSHR_FREE) && (addr_q == cmp_addr);

endmodule

// File: rtl/cache_ctrl_mshr.sv
// Cache controller front end: hit handling, MSHR allocation, registered
// ACE request issue and response retirement onto the array update port.
module cache_ctrl_mshr
    import cache_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int NUM_MSHR = 4,
    parameter int ID_W     = $clog2(NUM_MSHR)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_valid,
    output logic              cpu_ready,
    input  logic [1:0]        cpu_op,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cache_hit,
    input  logic [2:0]        line_state,
    output logic              ace_req_valid,
    input  logic              ace_req_ready,
    output logic [1:0]        ace_req_type,
    output logic [ADDR_W-1:0] ace_req_addr,
    output logic [ID_W-1:0]   ace_req_id,
    input  logic              ace_resp_valid,
    input  logic [ID_W-1:0]   ace_resp_id,
    input  logic              ace_resp_shared,
    input  logic              ace_resp_dirty,
    output logic              upd_valid,
    output logic [ADDR_W-1:0] upd_addr,
    output logic [2:0]        new_state,
    output logic              write_from_cpu,
    output logic              write_from_interconnect,
    output logic              cache_complete,
    output logic              proto_err
);

    logic [1:0]        ent_state [NUM_MSHR];
    logic [ADDR_W-1:0] ent_addr  [NUM_MSHR];
    logic [1:0]        ent_type  [NUM_MSHR];
    logic [NUM_MSHR-1:0] ent_free, ent_pend, ent_wait, ent_match;
    logic [NUM_MSHR-1:0] alloc_vec, issue_vec, retire_vec, cand;

    logic            run_q;
    logic            full, accept, is_write, lookup_hit, hit_upgrade, do_alloc;
    logic            handshake, resp_hit, resp_bad, pick_any;
    logic [ID_W-1:0] alloc_id, pick_id;
    ace_req_e        alloc_type;

    logic              req_valid_q, req_valid_d;
    ace_req_e          req_type_q, req_type_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [ID_W-1:0]   req_id_q, req_id_d;

    logic              upd_valid_q, upd_valid_d;
    logic [ADDR_W-1:0] upd_addr_q, upd_addr_d;
    logic [2:0]        new_state_q, new_state_d;
    logic              wfc_q, wfc_d, wfi_q, wfi_d;
    logic              complete_q, complete_d;
    logic              proto_err_q;

    for (genvar g = 0; g < NUM_MSHR; g++) begin : g_entry
        cache_mshr_entry #(.ADDR_W(ADDR_W)) u_entry (
            .clk        (clk),
            .rst_n      (rst_n),
            .alloc      (alloc_vec[g]),
            .alloc_addr (cpu_addr),
            .alloc_type (alloc_type),
            .issue      (issue_vec[g]),
            .retire     (retire_vec[g]),
            .cmp_addr   (cpu_addr),
            .state      (ent_state[g]),
            .addr       (ent_addr[g]),
            .req_type   (ent_type[g]),
            .match      (ent_match[g])
        );
        assign ent_free[g] = (ent_state[g] == MSHR_FREE);
        assign ent_pend[g] = (ent_state[g] == MSHR_PEND);
        assign ent_wait[g] = (ent_state[g] == MSHR_WAIT);
    end

    // Ready is held low in the response cycle so a retire never shares the update port.
    assign full      = ~|ent_free;
    assign cpu_ready = run_q && !full && !(|ent_match) && !ace_resp_valid;
    assign accept    = cpu_valid && cpu_ready;

    assign is_write    = (cpu_op == OP_WRITE);
    assign lookup_hit  = cache_hit && is_valid_line(line_state);
    assign hit_upgrade = lookup_hit && is_write &&
                         ((line_state == LS_SC) || (line_state == LS_SD));
    assign do_alloc    = accept && (!lookup_hit || hit_upgrade);
    assign alloc_type  = !is_write   ? ACE_READ_SHARED :
                         hit_upgrade ? ACE_CLEAN_UNIQUE : ACE_READ_UNIQUE;

    assign handshake = req_valid_q && ace_req_ready;
    assign resp_hit  = ace_resp_valid && ent_wait[ace_resp_id];
    assign resp_bad  = ace_resp_valid && !ent_wait[ace_resp_id];

    always_comb begin
        alloc_id = '0;
        for (int i = NUM_MSHR - 1; i >= 0; i--) begin
            if (ent_free[i]) alloc_id = i[ID_W-1:0];
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_MSHR; i++) begin
            alloc_vec[i]  = do_alloc  && (alloc_id    == i[ID_W-1:0]);
            issue_vec[i]  = handshake && (req_id_q    == i[ID_W-1:0]);
            retire_vec[i] = resp_hit  && (ace_resp_id == i[ID_W-1:0]);
        end
    end

    // The entry leaving PEND this cycle is excluded; a same-cycle allocation is
    // bypassed in so a miss can be presented on the very next cycle.
    assign cand     = (ent_pend & ~issue_vec) | alloc_vec;
    assign pick_any = |cand;

    always_comb begin
        pick_id = '0;
        for (int i = NUM_MSHR - 1; i >= 0; i--) begin
            if (cand[i]) pick_id = i[ID_W-1:0];
        end
    end

    always_comb begin
        req_valid_d = req_valid_q;
        req_type_d  = req_type_q;
        req_addr_d  = req_addr_q;
        req_id_d    = req_id_q;
        if (!req_valid_q || ace_req_ready) begin
            req_valid_d = pick_any;
            if (pick_any) begin
                req_id_d = pick_id;
                if (alloc_vec[pick_id]) begin
                    req_type_d = alloc_type;
                    req_addr_d = cpu_addr;
                end else begin
                    req_type_d = ace_req_e'(ent_type[pick_id]);
                    req_addr_d = ent_addr[pick_id];
                end
            end
        end
    end

    always_comb begin
        upd_valid_d = 1'b0;
        upd_addr_d  = upd_addr_q;
        new_state_d = new_state_q;
        wfc_d       = 1'b0;
        wfi_d       = 1'b0;
        complete_d  = 1'b0;
        if (resp_hit) begin
            upd_valid_d = 1'b1;
            upd_addr_d  = ent_addr[ace_resp_id];
            complete_d  = 1'b1;
            case (ent_type[ace_resp_id])
                ACE_READ_SHARED: begin
                    new_state_d = fill_state(ace_resp_shared, ace_resp_dirty);
                    wfi_d       = 1'b1;
                end
                ACE_READ_UNIQUE: begin
                    new_state_d = LS_UD;
                    wfi_d       = 1'b1;
                    wfc_d       = 1'b1;
                end
                default: begin
                    new_state_d = LS_UD;
                    wfc_d       = 1'b1;
                end
            endcase
        end else if (accept && !do_alloc) begin
            complete_d = 1'b1;
            if (is_write) begin
                upd_valid_d = 1'b1;
                upd_addr_d  = cpu_addr;
                new_state_d = LS_UD;
                wfc_d       = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q       <= 1'b0;
            req_valid_q <= 1'b0;
            req_type_q  <= ACE_READ_SHARED;
            req_addr_q  <= '0;
            req_id_q    <= '0;
            upd_valid_q <= 1'b0;
            upd_addr_q  <= '0;
            new_state_q <= LS_I;
            wfc_q       <= 1'b0;
            wfi_q       <= 1'b0;
            complete_q  <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            run_q       <= 1'b1;
            req_valid_q <= req_valid_d;
            req_type_q  <= req_type_d;
            req_addr_q  <= req_addr_d;
            req_id_q    <= req_id_d;
            upd_valid_q <= upd_valid_d;
            upd_addr_q  <= upd_addr_d;
            new_state_q <= new_state_d;
            wfc_q       <= wfc_d;
            wfi_q       <= wfi_d;
            complete_q  <= complete_d;
            proto_err_q <= proto_err_q | resp_bad;
        end
    end

    assign ace_req_valid           = req_valid_q;
    assign ace_req_type            = req_type_q;
    assign ace_req_addr            = req_addr_q;
    assign ace_req_id              = req_id_q;
    assign upd_valid               = upd_valid_q;
    assign upd_addr                = upd_addr_q;
    assign new_state               = new_state_q;
    assign write_from_cpu          = wfc_q;
    assign write_from_interconnect = wfi_q;
    assign cache_complete          = complete_q;
    assign proto_err               = proto_err_q;

endmodule

// File: tb/tb_cache_ctrl_mshr.sv
// Directed bench for cache_ctrl_mshr: hit paths, miss issue/retire, full
// stall, address-conflict stall, protocol error and mid-transaction reset.
module tb_cache_ctrl_mshr;

    localparam int ADDR_W   = 32;
    localparam int NUM_MSHR = 4;
    localparam int ID_W     = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cpu_valid, cpu_ready;
    logic [1:0]        cpu_op;
    logic [ADDR_W-1:0] cpu_addr;
    logic              cache_hit;
    logic [2:0]        line_state;
    logic              ace_req_valid, ace_req_ready;
    logic [1:0]        ace_req_type;
    logic [ADDR_W-1:0] ace_req_addr;
    logic [ID_W-1:0]   ace_req_id;
    logic              ace_resp_valid;
    logic [ID_W-1:0]   ace_resp_id;
    logic              ace_resp_shared, ace_resp_dirty;
    logic              upd_valid;
    logic [ADDR_W-1:0] upd_addr;
    logic [2:0]        new_state;
    logic              write_from_cpu, write_from_interconnect;
    logic              cache_complete, proto_err;

    int n_checks = 0;
    int n_errors = 0;

    cache_ctrl_mshr #(.ADDR_W(ADDR_W), .NUM_MSHR(NUM_MSHR)) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .cpu_valid               (cpu_valid),
        .cpu_ready               (cpu_ready),
        .cpu_op                  (cpu_op),
        .cpu_addr                (cpu_addr),
        .cache_hit               (cache_hit),
        .line_state              (line_state),
        .ace_req_valid           (ace_req_valid),
        .ace_req_ready           (ace_req_ready),
        .ace_req_type            (ace_req_type),
        .ace_req_addr            (ace_req_addr),
        .ace_req_id              (ace_req_id),
        .ace_resp_valid          (ace_resp_valid),
        .ace_resp_id             (ace_resp_id),
        .ace_resp_shared         (ace_resp_shared),
        .ace_resp_dirty          (ace_resp_dirty),
        .upd_valid               (upd_valid),
        .upd_addr                (upd_addr),
        .new_state               (new_state),
        .write_from_cpu          (write_from_cpu),
        .write_from_interconnect (write_from_interconnect),
        .cache_complete          (cache_complete),
        .proto_err               (proto_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Outputs settle 1 ns after the rising edge; inputs change at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [1:0] op, input logic [ADDR_W-1:0] a,
                       input logic hit, input logic [2:0] st);
        cpu_valid  = 1'b1;
        cpu_op     = op;
        cpu_addr   = a;
        cache_hit  = hit;
        line_state = st;
        #1;
    endtask

    task automatic resp(input logic [ID_W-1:0] id, input logic sh, input logic dt);
        ace_resp_valid  = 1'b1;
        ace_resp_id     = id;
        ace_resp_shared = sh;
        ace_resp_dirty  = dt;
        #1;
    endtask

    task automatic idle();
        cpu_valid      = 1'b0;
        cpu_op         = 2'b00;
        cpu_addr       = '0;
        cache_hit      = 1'b0;
        line_state     = 3'b100;
        ace_resp_valid = 1'b0;
        ace_resp_id    = '0;
        ace_resp_shared = 1'b0;
        ace_resp_dirty  = 1'b0;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_cpu_ready"},  cpu_ready, 0);
        check({pfx, "_req_valid"},  ace_req_valid, 0);
        check({pfx, "_req_addr"},   ace_req_addr, 0);
        check({pfx, "_upd_valid"},  upd_valid, 0);
        check({pfx, "_upd_addr"},   upd_addr, 0);
        check({pfx, "_new_state"},  new_state, 3'b100);
        check({pfx, "_wfc"},        write_from_cpu, 0);
        check({pfx, "_wfi"},        write_from_interconnect, 0);
        check({pfx, "_complete"},   cache_complete, 0);
        check({pfx, "_proto_err"},  proto_err, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        idle();
        ace_req_ready = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        check_reset_outputs("rst");
        rst_n = 1'b1;
        tick();

        // Read hit 0x40 in SC
        req(2'b00, 32'h40, 1'b1, 3'b010);
        check("rh_ready", cpu_ready, 1);
        tick(); idle();
        check("rh_complete", cache_complete, 1);
        check("rh_upd", upd_valid, 0);
        check("rh_noreq", ace_req_valid, 0);
        tick();
        check("rh_pulse_end", cache_complete, 0);

        // Write hit 0x80 in UC
        req(2'b01, 32'h80, 1'b1, 3'b001);
        tick(); idle();
        check("wh_upd", upd_valid, 1);
        check("wh_addr", upd_addr, 32'h80);
        check("wh_state", new_state, 3'b011);
        check("wh_wfc", write_from_cpu, 1);
        check("wh_wfi", write_from_interconnect, 0);
        check("wh_complete", cache_complete, 1);
        check("wh_noreq", ace_req_valid, 0);

        // Read miss 0x100, interconnect ready
        ace_req_ready = 1'b1;
        req(2'b00, 32'h100, 1'b0, 3'b010);
        tick(); idle();
        check("rm_req_valid", ace_req_valid, 1);
        check("rm_req_type", ace_req_type, 2'b00);
        check("rm_req_id", ace_req_id, 0);
        check("rm_req_addr", ace_req_addr, 32'h100);
        check("rm_no_complete", cache_complete, 0);
        tick();
        check("rm_req_drop", ace_req_valid, 0);
        resp(0, 1'b1, 1'b0);
        check("rm_resp_stall", cpu_ready, 0);
        tick(); idle();
        check("rm_upd", upd_valid, 1);
        check("rm_upd_addr", upd_addr, 32'h100);
        check("rm_state", new_state, 3'b010);
        check("rm_wfi", write_from_interconnect, 1);
        check("rm_wfc", write_from_cpu, 0);
        check("rm_complete", cache_complete, 1);

        // Op 1x miss treated as read, then a write miss issued back to back
        req(2'b11, 32'h500, 1'b0, 3'b100);
        tick();
        check("op3_type", ace_req_type, 2'b00);
        check("op3_id", ace_req_id, 0);
        req(2'b01, 32'h600, 1'b0, 3'b000);
        tick(); idle();
        check("wm_type", ace_req_type, 2'b01);
        check("wm_id", ace_req_id, 1);
        check("wm_addr", ace_req_addr, 32'h600);
        tick();
        check("wm_req_drop", ace_req_valid, 0);
        resp(1, 1'b0, 1'b0);
        tick(); idle();
        check("wm_state", new_state, 3'b011);
        check("wm_addr_upd", upd_addr, 32'h600);
        check("wm_wfi", write_from_interconnect, 1);
        check("wm_wfc", write_from_cpu, 1);
        resp(0, 1'b1, 1'b1);
        tick(); idle();
        check("op3_state_sd", new_state, 3'b101);
        check("op3_wfc", write_from_cpu, 0);
        check("op3_complete", cache_complete, 1);

        // Four misses fill the MSHRs while the interconnect stalls
        ace_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req(2'b00, 32'h200 + 32'(i) * 32'h10, 1'b0, 3'b100);
            check($sformatf("full_acc%0d", i), cpu_ready, 1);
            tick();
        end
        req(2'b00, 32'h240, 1'b0, 3'b100);
        check("full_ready", cpu_ready, 0);
        check("full_hold_id", ace_req_id, 0);
        check("full_hold_addr", ace_req_addr, 32'h200);
        tick();
        check("full_hold_valid", ace_req_valid, 1);
        check("full_hold_id2", ace_req_id, 0);
        check("full_hold_addr2", ace_req_addr, 32'h200);
        ace_req_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            tick();
            check($sformatf("issue_id%0d", i), ace_req_id, i);
            check($sformatf("issue_addr%0d", i), ace_req_addr, 32'h200 + 32'(i) * 32'h10);
        end
        tick();
        ace_req_ready = 1'b0;
        check("issue_drain", ace_req_valid, 0);
        check("full_still", cpu_ready, 0);
        resp(2, 1'b0, 1'b0);
        check("full_resp_stall", cpu_ready, 0);
        tick();
        ace_resp_valid = 1'b0;
        #1;
        check("ret2_complete", cache_complete, 1);
        check("ret2_addr", upd_addr, 32'h220);
        check("ret2_state", new_state, 3'b001);
        check("fifth_ready", cpu_ready, 1);
        tick();
        cpu_valid = 1'b0;
        check("fifth_req_valid", ace_req_valid, 1);
        check("fifth_req_id", ace_req_id, 2);
        check("fifth_req_addr", ace_req_addr, 32'h240);
        check("fifth_no_complete", cache_complete, 0);
        resp(0, 1'b0, 1'b1);
        tick(); idle();
        check("ret0_complete", cache_complete, 1);
        check("ret0_addr", upd_addr, 32'h200);
        check("ret0_state", new_state, 3'b011);
        do_reset();

        // Write hit in SC upgrades with CleanUnique; same-line request stalls
        req(2'b01, 32'h300, 1'b1, 3'b010);
        tick(); idle();
        check("cu_req_valid", ace_req_valid, 1);
        check("cu_req_type", ace_req_type, 2'b10);
        check("cu_req_addr", ace_req_addr, 32'h300);
        check("cu_no_upd", upd_valid, 0);
        check("cu_no_complete", cache_complete, 0);
        req(2'b00, 32'h300, 1'b1, 3'b010);
        check("cu_conflict", cpu_ready, 0);
        tick();
        check("cu_conflict2", cpu_ready, 0);
        check("cu_conflict_noc", cache_complete, 0);
        ace_req_ready = 1'b1;
        tick();
        ace_req_ready = 1'b0;
        check("cu_issued", ace_req_valid, 0);
        resp(1, 1'b0, 1'b0);
        tick();
        ace_resp_valid = 1'b0;
        #1;
        check("perr_set", proto_err, 1);
        check("perr_no_complete", cache_complete, 0);
        check("perr_no_upd", upd_valid, 0);
        tick();
        check("perr_sticky", proto_err, 1);
        resp(0, 1'b0, 1'b0);
        tick();
        ace_resp_valid = 1'b0;
        #1;
        check("cu_upd", upd_valid, 1);
        check("cu_upd_addr", upd_addr, 32'h300);
        check("cu_state", new_state, 3'b011);
        check("cu_wfc", write_from_cpu, 1);
        check("cu_wfi", write_from_interconnect, 0);
        check("cu_complete", cache_complete, 1);
        check("cu_unstall", cpu_ready, 1);
        tick(); idle();
        check("cu_rh_complete", cache_complete, 1);
        check("cu_rh_noupd", upd_valid, 0);
        check("perr_sticky2", proto_err, 1);

        // Reset while an entry is in WAIT, then a stale response
        ace_req_ready = 1'b1;
        req(2'b00, 32'h400, 1'b0, 3'b100);
        tick(); idle();
        check("mid_req_valid", ace_req_valid, 1);
        tick();
        ace_req_ready = 1'b0;
        check("mid_issued", ace_req_valid, 0);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_complete", cache_complete, 0);
        check("post_rst_ready", cpu_ready, 1);
        resp(0, 1'b1, 1'b0);
        tick(); idle();
        check("stale_perr", proto_err, 1);
        check("stale_no_complete", cache_complete, 0);
        check("stale_no_upd", upd_valid, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/cache_ctrl_mshr.md
CACHE_CTRL_MSHR -- requirements
Module: cache_ctrl_mshr

Interface
REQ-001 ADDR_W, 32, line-address width.
REQ-002 NUM_MSHR, 4, outstanding-miss entries (power of 2, >=2); ID_W = clog2(NUM_MSHR).
REQ-003 clk  input  1  sole clock; one clock, all state updates on rising edge.
REQ-004 reset  input  1  reset is asynchronous and active-low.
REQ-005 cpu_valid  input  1  CPU request valid.
REQ-006 cpu_ready  output  1  request accepted when cpu_valid && cpu_ready.
REQ-007 cpu_op  input  2  00 read, 01 write; 1x treated as read.
REQ-008 cpu_addr  input  ADDR_W  request line address.
REQ-009 cache_hit  input  1  tag hit for cpu_addr, valid in the same cycle.
REQ-010 line_state  input  3  current state of the cpu_addr line, valid in the same cycle.
REQ-011 ace_req_valid  output  1  coherent request valid.
REQ-012 ace_req_ready  input  1  interconnect accepts request.
REQ-013 ace_req_type  output  2  00 ReadShared, 01 ReadUnique, 10 CleanUnique.
REQ-014 ace_req_addr  output  ADDR_W  request address.
REQ-015 ace_req_id  output  ID_W  MSHR index.
REQ-016 ace_resp_valid  input  1  single-cycle response.
REQ-017 ace_resp_id  input  ID_W  responding MSHR index.
REQ-018 ace_resp_shared  input  1  PassShared.
REQ-019 ace_resp_dirty  input  1  PassDirty.
REQ-020 upd_valid  output  1  array update strobe.
REQ-021 upd_addr  output  ADDR_W  update address.
REQ-022 new_state  output  3  state written to the line.
REQ-023 write_from_cpu  output  1  data array takes CPU store data.
REQ-024 write_from_interconnect  output  1  data array takes fill data.
REQ-025 cache_complete  output  1  one-cycle pulse when a CPU request retires.
REQ-026 proto_err  output  1  sticky; set by a response to a non-WAIT id.

Function
REQ-027 Encodings: UC=001, SC=010, UD=011, I=100, SD=101; any other code is treated as I. A lookup with cache_hit=0 or state I is a miss.
REQ-028 cpu_ready = !full && no non-FREE entry with addr==cpu_addr && !ace_resp_valid. It may depend combinationally on cpu_addr, never on cpu_valid.
REQ-029 Read hit: cache_complete=1 at cycle+1; upd_valid=0.
REQ-030 Write hit in UC/UD: at cycle+1, upd_valid=1, upd_addr=cpu_addr, new_state=UD, write_from_cpu=1, cache_complete=1.
REQ-031 Allocation: a miss, or a write hit in SC/SD, allocates the lowest-index FREE entry as PEND.
- Request type: read miss -> ReadShared; write miss -> ReadUnique; write hit SC/SD -> CleanUnique.
- No completion pulse is generated at allocation.
REQ-032 Entry FSM: FREE -> PEND (allocate) -> WAIT (ace_req handshake) -> FREE (response).
REQ-033 ace_req_* outputs are registered.
- Source: lowest-index PEND entry; earliest assertion is the cycle after allocation.
- Selection is frozen and fields are stable while ace_req_valid && !ace_req_ready.
- Throughput: one request per cycle.
REQ-034 A response to a WAIT id frees the entry. At cycle+1: upd_valid=1, upd_addr=entry addr, cache_complete=1.
- ReadShared: new_state from {shared,dirty} = 00->UC, 01->UD, 10->SC, 11->SD; write_from_interconnect=1.
- ReadUnique: new_state=UD; write_from_interconnect=1 and write_from_cpu=1.
- CleanUnique: new_state=UD; write_from_cpu=1 only.
REQ-035 A response to a non-WAIT id is ignored and sets proto_err.
REQ-036 A response and an ace_req handshake in the same cycle (different ids) both take effect. The response-cycle stall prevents update-port collisions.
REQ-037 Full (all entries non-FREE): cpu_ready=0. A retired entry is re-allocatable from the cycle after its response.

Reset
REQ-038 reset low: all entries FREE; all outputs 0 except new_state=I (100); proto_err cleared; cpu_ready=0 while reset is low.
REQ-039 Reset mid-transaction drops outstanding entries with no completion. A later stale response sets proto_err.

Structure
REQ-040 Package cache_pkg: line-state, cpu-op, ace-request-type and MSHR-state enums, plus the {shared,dirty}->state function.
REQ-041 Sub-module cache_mshr_entry (generate loop) holds state, addr, type and the address compare. Arbitration, hit path and output registers stay in the top.

Verification
REQ-042 Read hit at 0x40, state SC -> cache_complete at cycle+1, upd_valid=0, no ace_req.
REQ-043 Write hit at 0x80, state UC -> cycle+1: upd_valid=1, new_state=011, write_from_cpu=1, cache_complete=1.
REQ-044 Read miss at 0x100, ready=1 -> ReadShared id0 at cycle+1; response id0 shared=1 dirty=0 -> new_state=010, write_from_interconnect=1.
REQ-045 Four misses at 0x200-0x230 with ready=0 -> fifth request sees cpu_ready=0; id0 held stable; responses id2 then id0 -> completions in that order; fifth request accepted the cycle after the first retire.
REQ-046 Write hit SC at 0x300 -> CleanUnique; a repeat request to 0x300 stalls until retire; response to a FREE id sets proto_err and it stays set; reset during WAIT -> all outputs return to reset values.
